// File: rtl/rf_wb_pkg.sv
// Shared types and sizes for the register-file writeback path.
package rf_wb_pkg;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int NREG   = 32;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;
endpackage

// File: rtl/rf_wb_fifo.sv
// Synchronous FIFO of writeback requests; head is read combinationally.
// Push is ignored when full and pop when empty; no bypass from push to head.
module rf_wb_fifo
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     push_i,
    input  wb_req_t                  push_dat_i,
    input  logic                     pop_i,
    output wb_req_t                  head_dat_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int PW = $clog2(DEPTH);

    wb_req_t       mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign full_o     = (count_q == (PW+1)'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign head_dat_o = mem_q[rd_ptr_q];
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (!do_push && do_pop) count_q <= count_q - 1'b1;
        end
    end

    // Storage needs no reset: only slots behind a valid count are ever read.
    always_ff @(posedge i_clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
    end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates ALU and buffered load writebacks onto the single regfile write port,
// tracks in-flight loads in a scoreboard and stalls issue on RAW/WAW hazards.
module rf_wb_arbiter
    import rf_wb_pkg::*;
#(
    parameter int LD_FIFO_DEPTH = 4,
    parameter int STARVE_MAX    = 3
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_issue_valid,
    input  logic              i_issue_is_load,
    input  logic [4:0]        i_issue_rs1,
    input  logic [4:0]        i_issue_rs2,
    input  logic [4:0]        i_issue_rd,
    output logic              o_issue_stall,
    input  logic              i_alu_valid,
    input  logic [4:0]        i_alu_rd,
    input  logic [XLEN-1:0]   i_alu_data,
    output logic              o_alu_ready,
    input  logic              i_ld_valid,
    input  logic [4:0]        i_ld_rd,
    input  logic [XLEN-1:0]   i_ld_data,
    output logic              o_ld_ready,
    output logic [4:0]        o_rd_addr,
    output logic [XLEN-1:0]   o_rd_data,
    output logic              o_rd_wren,
    output logic              o_err
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int CW = $clog2(LD_FIFO_DEPTH) + 1;

    wb_req_t         ld_req;
    wb_req_t         head;
    logic            full;
    logic            empty;
    logic [CW-1:0]   count;
    logic            ld_acc;
    logic            alu_acc;
    logic            pop;
    logic            issue_acc;

    logic [SW-1:0]   starve_q, starve_d;
    logic [NREG-1:0] pending_q, pending_d;
    logic            wren_q, wren_d;
    logic            is_load_q, is_load_d;
    logic [4:0]      addr_q, addr_d;
    logic [XLEN-1:0] data_q, data_d;
    logic            err_q, err_d;

    assign ld_req = '{rd: i_ld_rd, data: i_ld_data};

    rf_wb_fifo #(.DEPTH(LD_FIFO_DEPTH)) u_ld_fifo (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .push_i     (ld_acc),
        .push_dat_i (ld_req),
        .pop_i      (pop),
        .head_dat_o (head),
        .full_o     (full),
        .empty_o    (empty),
        .count_o    (count)
    );

    assign o_ld_ready  = (count != CW'(LD_FIFO_DEPTH));
    assign o_alu_ready = !(full && (starve_q >= SW'(STARVE_MAX)));
    assign ld_acc      = i_ld_valid && o_ld_ready;
    assign alu_acc     = i_alu_valid && o_alu_ready;
    assign pop         = !alu_acc && !empty;

    // pending_q[0] is held at 0, so x0 operands never stall.
    assign o_issue_stall = i_issue_valid &&
        (pending_q[i_issue_rs1] || pending_q[i_issue_rs2] || pending_q[i_issue_rd]);
    assign issue_acc = i_issue_valid && !o_issue_stall && i_issue_is_load && (i_issue_rd != '0);

    always_comb begin
        starve_d  = starve_q;
        wren_d    = 1'b0;
        is_load_d = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        pending_d = pending_q;
        err_d     = err_q;

        if (pop || empty)                   starve_d = '0;
        else if (starve_q < SW'(STARVE_MAX)) starve_d = starve_q + 1'b1;

        if (alu_acc) begin
            wren_d = (i_alu_rd != '0);
            addr_d = i_alu_rd;
            data_d = i_alu_data;
        end else if (pop) begin
            wren_d    = (head.rd != '0);
            is_load_d = 1'b1;
            addr_d    = head.rd;
            data_d    = head.data;
        end

        // Clear as the load write commits, so the stall drops the following cycle.
        if (wren_q && is_load_q) pending_d[addr_q] = 1'b0;
        if (issue_acc)           pending_d[i_issue_rd] = 1'b1;
        pending_d[0] = 1'b0;

        if (ld_acc && (i_ld_rd != '0) && !pending_q[i_ld_rd]) err_d = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            starve_q  <= '0;
            pending_q <= '0;
            wren_q    <= 1'b0;
            is_load_q <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            starve_q  <= starve_d;
            pending_q <= pending_d;
            wren_q    <= wren_d;
            is_load_q <= is_load_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            err_q     <= err_d;
        end
    end

    assign o_rd_wren = wren_q;
    assign o_rd_addr = addr_q;
    assign o_rd_data = data_q;
    assign o_err     = err_q;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: hand-computed expectations checked with immediate assertions.
module tb_rf_wb_arbiter;
    logic        i_clk;
    logic        i_reset;
    logic        i_issue_valid, i_issue_is_load;
    logic [4:0]  i_issue_rs1, i_issue_rs2, i_issue_rd;
    logic        o_issue_stall;
    logic        i_alu_valid;
    logic [4:0]  i_alu_rd;
    logic [31:0] i_alu_data;
    logic        o_alu_ready;
    logic        i_ld_valid;
    logic [4:0]  i_ld_rd;
    logic [31:0] i_ld_data;
    logic        o_ld_ready;
    logic [4:0]  o_rd_addr;
    logic [31:0] o_rd_data;
    logic        o_rd_wren;
    logic        o_err;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    rf_wb_arbiter dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_issue_valid   (i_issue_valid),
        .i_issue_is_load (i_issue_is_load),
        .i_issue_rs1     (i_issue_rs1),
        .i_issue_rs2     (i_issue_rs2),
        .i_issue_rd      (i_issue_rd),
        .o_issue_stall   (o_issue_stall),
        .i_alu_valid     (i_alu_valid),
        .i_alu_rd        (i_alu_rd),
        .i_alu_data      (i_alu_data),
        .o_alu_ready     (o_alu_ready),
        .i_ld_valid      (i_ld_valid),
        .i_ld_rd         (i_ld_rd),
        .i_ld_data       (i_ld_data),
        .o_ld_ready      (o_ld_ready),
        .o_rd_addr       (o_rd_addr),
        .o_rd_data       (o_rd_data),
        .o_rd_wren       (o_rd_wren),
        .o_err           (o_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            miss_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        i_reset = 1'b0;
        i_issue_valid = 0; i_issue_is_load = 0;
        i_issue_rs1 = 0; i_issue_rs2 = 0; i_issue_rd = 0;
        i_alu_valid = 0; i_alu_rd = 0; i_alu_data = 0;
        i_ld_valid = 0; i_ld_rd = 0; i_ld_data = 0;
        repeat (2) @(posedge i_clk);
        #1 i_reset = 1'b1;
        #1;
        chk("rst_wren",      o_rd_wren,     0);
        chk("rst_ld_ready",  o_ld_ready,    1);
        chk("rst_alu_ready", o_alu_ready,   1);
        chk("rst_stall",     o_issue_stall, 0);
        chk("rst_err",       o_err,         0);

        // ALU writeback, latency 1; rd=0 suppressed
        i_alu_valid = 1; i_alu_rd = 5; i_alu_data = 32'hDEADBEEF;
        tick();
        chk("alu_wren", o_rd_wren, 1);
        chk("alu_addr", o_rd_addr, 5);
        chk("alu_data", o_rd_data, 32'hDEADBEEF);
        i_alu_rd = 0; i_alu_data = 32'h1;
        tick();
        chk("alu_rd0_wren", o_rd_wren, 0);
        i_alu_valid = 0;

        // load x7 pending, RAW stall until its write commits
        i_issue_valid = 1; i_issue_is_load = 1; i_issue_rd = 7;
        #1 chk("ld_issue_stall", o_issue_stall, 0);
        tick();
        i_issue_is_load = 0; i_issue_rs1 = 7; i_issue_rd = 8;
        #1 chk("raw_stall", o_issue_stall, 1);
        i_ld_valid = 1; i_ld_rd = 7; i_ld_data = 32'h1234;
        #1 chk("ld7_ready", o_ld_ready, 1);
        tick();
        i_ld_valid = 0;
        #1 chk("raw_stall_fifo", o_issue_stall, 1);
        tick();
        chk("ld7_wren", o_rd_wren, 1);
        chk("ld7_addr", o_rd_addr, 7);
        chk("ld7_data", o_rd_data, 32'h1234);
        chk("raw_stall_commit", o_issue_stall, 1);
        tick();
        chk("raw_release", o_issue_stall, 0);
        chk("ld7_wren_done", o_rd_wren, 0);
        chk("err_clean1", o_err, 0);
        i_issue_valid = 0; i_issue_rs1 = 0;

        // loads 10..14 pending
        for (int r = 10; r <= 14; r++) begin
            i_issue_valid = 1; i_issue_is_load = 1; i_issue_rd = 5'(r);
            tick();
        end
        i_issue_valid = 0; i_issue_is_load = 0; i_issue_rd = 0;

        // ALU and load together: ALU first, load next cycle
        i_alu_valid = 1; i_alu_rd = 3; i_alu_data = 32'hAAAA;
        i_ld_valid = 1; i_ld_rd = 10; i_ld_data = 32'h1010;
        #1 chk("both_alu_ready", o_alu_ready, 1);
        tick();
        i_alu_valid = 0; i_ld_valid = 0;
        chk("both_first_addr", o_rd_addr, 3);
        chk("both_first_data", o_rd_data, 32'hAAAA);
        tick();
        chk("both_second_wren", o_rd_wren, 1);
        chk("both_second_addr", o_rd_addr, 10);
        chk("both_second_data", o_rd_data, 32'h1010);

        // fill FIFO behind continuous ALU traffic
        i_alu_valid = 1; i_alu_rd = 4; i_alu_data = 32'h4444;
        for (int k = 0; k < 4; k++) begin
            i_ld_valid = 1; i_ld_rd = 5'(11 + k); i_ld_data = 32'h1011 + k;
            #1;
            chk("fill_alu_ready", o_alu_ready, 1);
            chk("fill_ld_ready",  o_ld_ready,  1);
            tick();
        end
        // full: rd=15 response must not enter even though the head pops this cycle
        i_ld_rd = 15; i_ld_data = 32'hFFFF;
        #1;
        chk("full_ld_ready",  o_ld_ready,  0);
        chk("starve_alu_hold", o_alu_ready, 0);
        chk("fill_last_alu_addr", o_rd_addr, 4);
        tick();
        i_ld_valid = 0;
        chk("starve_pop_addr", o_rd_addr, 11);
        chk("starve_pop_data", o_rd_data, 32'h1011);
        chk("starve_alu_back", o_alu_ready, 1);
        chk("starve_ld_back",  o_ld_ready,  1);
        tick();
        i_alu_valid = 0;
        chk("alu_after_starve", o_rd_addr, 4);
        tick();
        chk("drain12", o_rd_addr, 12);
        tick();
        chk("drain13", o_rd_addr, 13);
        tick();
        chk("drain14", o_rd_addr, 14);
        tick();
        chk("drain_empty_wren", o_rd_wren, 0);
        chk("err_clean2", o_err, 0);

        // unexpected load response: sticky error
        i_ld_valid = 1; i_ld_rd = 9; i_ld_data = 32'h9999;
        tick();
        i_ld_valid = 0;
        chk("err_set", o_err, 1);
        tick();
        chk("err_ld9_addr", o_rd_addr, 9);
        chk("err_sticky", o_err, 1);
        tick();

        // reset in the middle of a burst
        i_issue_valid = 1; i_issue_is_load = 1; i_issue_rd = 20;
        tick();
        i_issue_valid = 0; i_issue_is_load = 0; i_issue_rd = 0;
        i_alu_valid = 1; i_alu_rd = 6; i_alu_data = 32'h6666;
        i_ld_valid = 1; i_ld_rd = 20; i_ld_data = 32'h2020;
        tick();
        i_alu_valid = 0; i_ld_valid = 0;
        chk("pre_rst_wren", o_rd_wren, 1);
        i_reset = 1'b0;
        #1;
        chk("mid_rst_wren", o_rd_wren, 0);
        chk("mid_rst_addr", o_rd_addr, 0);
        chk("mid_rst_data", o_rd_data, 0);
        chk("mid_rst_err",  o_err,     0);
        i_reset = 1'b1;
        tick();
        chk("post_rst_fifo_empty", o_rd_wren, 0);
        tick();
        chk("post_rst_wren", o_rd_wren, 0);
        i_issue_valid = 1; i_issue_rs1 = 20; i_issue_rd = 21;
        #1 chk("post_rst_scoreboard", o_issue_stall, 0);
        i_issue_valid = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end
endmodule
